// File: rtl/proc_pkg.sv
// Shared core/memory types: default bus widths and the read-return tag carried
// alongside each memory read until its data comes back.
package proc_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

  localparam rd_tag_t TAG_NONE = '{valid: 1'b0, id: REQ_IF};

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the shared memory port.
// slave = the arbiter, master = the core plus the memory around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// Delay line of read-owner tags; the tail lines up with memory read data
// DEPTH cycles after the grant.
module rd_tag_pipe
  import proc_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store:
// data has priority, fetch is forced through after MAX_STREAK data wins.
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int READ_LAT   = 1,
  parameter int MAX_STREAK = 3
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic              if_gnt;
  logic              d_gnt;
  logic [3:0]        streak;
  logic              streak_full;
  logic [ADDR_W-1:0] mem_addr_mux;
  logic [DATA_W-1:0] mem_wdata_mux;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;

  assign streak_full = (streak == STREAK_MAX);

  // Grants are held off while reset is asserted, even with requests pending.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (bus.if_req && (!bus.d_req || streak_full)) if_gnt = 1'b1;
      else if (bus.d_req)                            d_gnt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= 4'd0;
    end else if (if_gnt || !bus.if_req) begin
      streak <= 4'd0;
    end else if (d_gnt && !streak_full) begin
      streak <= streak + 4'd1;
    end
  end

  always_comb begin
    mem_addr_mux  = '0;
    mem_wdata_mux = '0;
    if (if_gnt) begin
      mem_addr_mux = bus.if_addr;
    end else if (d_gnt) begin
      mem_addr_mux  = bus.d_addr;
      mem_wdata_mux = bus.d_wdata;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = if_gnt | d_gnt;
  assign bus.mem_we    = d_gnt & bus.d_we;
  assign bus.mem_addr  = mem_addr_mux;
  assign bus.mem_wdata = mem_wdata_mux;

  always_comb begin
    tag_in = TAG_NONE;
    if (if_gnt)                   tag_in = '{valid: 1'b1, id: REQ_IF};
    else if (d_gnt && !bus.d_we)  tag_in = '{valid: 1'b1, id: REQ_D};
  end

  rd_tag_pipe #(
    .DEPTH (READ_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign bus.if_rvalid = tag_out.valid && (tag_out.id == REQ_IF);
  assign bus.d_rvalid  = tag_out.valid && (tag_out.id == REQ_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (read latency 1 and 3) driven by identical requests, each with its
// own memory, compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  import proc_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MS = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .MAX_STREAK(MS)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .MAX_STREAK(MS)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  assign bus_a.if_req = if_req;  assign bus_b.if_req = if_req;
  assign bus_a.if_addr = if_addr; assign bus_b.if_addr = if_addr;
  assign bus_a.d_req = d_req;    assign bus_b.d_req = d_req;
  assign bus_a.d_we = d_we;      assign bus_b.d_we = d_we;
  assign bus_a.d_addr = d_addr;  assign bus_b.d_addr = d_addr;
  assign bus_a.d_wdata = d_wdata; assign bus_b.d_wdata = d_wdata;

  // Memories: reads capture at the grant edge, then age READ_LAT cycles.
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] rp_a;
  logic [DW-1:0] rp_b [3];

  always @(posedge clk) begin
    rp_a <= (bus_a.mem_en && !bus_a.mem_we) ? mem_a[bus_a.mem_addr[7:0]] : 16'hDEAD;
    if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
    rp_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? mem_b[bus_b.mem_addr[7:0]] : 16'hDEAD;
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
    if (bus_b.mem_en && bus_b.mem_we) mem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
  end
  assign bus_a.mem_rdata = rp_a;
  assign bus_b.mem_rdata = rp_b[2];

  logic [1:0]    o_ifg, o_dg, o_en, o_we, o_ifv, o_dv;
  logic [AW-1:0] o_addr [2];
  logic [DW-1:0] o_wd [2], o_ifd [2], o_dd [2];
  assign o_ifg = {bus_b.if_gnt, bus_a.if_gnt};
  assign o_dg  = {bus_b.d_gnt, bus_a.d_gnt};
  assign o_en  = {bus_b.mem_en, bus_a.mem_en};
  assign o_we  = {bus_b.mem_we, bus_a.mem_we};
  assign o_ifv = {bus_b.if_rvalid, bus_a.if_rvalid};
  assign o_dv  = {bus_b.d_rvalid, bus_a.d_rvalid};
  assign o_addr[0] = bus_a.mem_addr;  assign o_addr[1] = bus_b.mem_addr;
  assign o_wd[0]   = bus_a.mem_wdata; assign o_wd[1]   = bus_b.mem_wdata;
  assign o_ifd[0]  = bus_a.if_rdata;  assign o_ifd[1]  = bus_b.if_rdata;
  assign o_dd[0]   = bus_a.d_rdata;   assign o_dd[1]   = bus_b.d_rdata;

  // Reference model state
  typedef struct {
    int            due;
    bit            is_d;
    logic [DW-1:0] data;
  } ret_t;

  logic [DW-1:0] ref_mem [256];
  ret_t          q_a [$];
  ret_t          q_b [$];
  int            streak_m;
  int            cyc;
  int            n_chk;
  int            n_bad;

  function automatic logic [DW-1:0] init_val(input int i);
    return 16'(i * 16'h0101) ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_cycle(output bit gi, output bit gd);
    bit    eif, ed, hit;
    ret_t  r;
    string nm;
    eif = 1'b0;
    ed  = 1'b0;
    if (rst_n) begin
      if (if_req && d_req) begin
        ed  = (streak_m != MS);
        eif = !ed;
      end else begin
        eif = if_req;
        ed  = d_req;
      end
    end
    for (int k = 0; k < 2; k++) begin
      nm  = (k == 0) ? "lat1" : "lat3";
      hit = 1'b0;
      r   = '{0, 1'b0, '0};
      if (k == 0) begin
        if (q_a.size() > 0 && q_a[0].due == cyc) begin r = q_a.pop_front(); hit = 1'b1; end
      end else begin
        if (q_b.size() > 0 && q_b[0].due == cyc) begin r = q_b.pop_front(); hit = 1'b1; end
      end
      chk({nm, ".if_gnt"},    32'(o_ifg[k]), 32'(eif));
      chk({nm, ".d_gnt"},     32'(o_dg[k]),  32'(ed));
      chk({nm, ".mem_en"},    32'(o_en[k]),  32'(eif | ed));
      chk({nm, ".mem_we"},    32'(o_we[k]),  32'(ed & d_we));
      chk({nm, ".mem_addr"},  32'(o_addr[k]), eif ? 32'(if_addr) : ed ? 32'(d_addr) : 32'd0);
      chk({nm, ".mem_wdata"}, 32'(o_wd[k]),  ed ? 32'(d_wdata) : 32'd0);
      chk({nm, ".if_rvalid"}, 32'(o_ifv[k]), 32'(hit && !r.is_d));
      chk({nm, ".if_rdata"},  32'(o_ifd[k]), (hit && !r.is_d) ? 32'(r.data) : 32'd0);
      chk({nm, ".d_rvalid"},  32'(o_dv[k]),  32'(hit && r.is_d));
      chk({nm, ".d_rdata"},   32'(o_dd[k]),  (hit && r.is_d) ? 32'(r.data) : 32'd0);
      chk({nm, ".both_rvalid"}, 32'(o_ifv[k] & o_dv[k]), 32'd0);
    end
    if (eif) begin
      q_a.push_back('{cyc + 1, 1'b0, ref_mem[if_addr[7:0]]});
      q_b.push_back('{cyc + 3, 1'b0, ref_mem[if_addr[7:0]]});
    end
    if (ed && !d_we) begin
      q_a.push_back('{cyc + 1, 1'b1, ref_mem[d_addr[7:0]]});
      q_b.push_back('{cyc + 3, 1'b1, ref_mem[d_addr[7:0]]});
    end
    if (ed && d_we) ref_mem[d_addr[7:0]] = d_wdata;
    if (!rst_n || eif || !if_req) streak_m = 0;
    else if (ed && streak_m < MS) streak_m++;
    gi = eif;
    gd = ed;
  endtask

  // Called just after a rising edge: apply inputs, check at the falling edge.
  task automatic run_cycle(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dwe,
                           input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                           output bit gi, output bit gd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    check_cycle(gi, gd);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    bit gi, gd;
    for (int i = 0; i < n; i++) run_cycle(0, '0, 0, 0, '0, '0, gi, gd);
  endtask

  initial begin
    bit            gi, gd;
    logic [7:0]    pat;
    bit            p_ir, p_dr, p_dwe;
    logic [AW-1:0] p_ia, p_da;
    logic [DW-1:0] p_dwd;

    n_chk = 0; n_bad = 0; cyc = 0; streak_m = 0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = init_val(i); mem_b[i] = init_val(i); ref_mem[i] = init_val(i);
    end
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset with requests active: nothing granted
    run_cycle(1, 16'h4, 1, 0, 16'h8, 16'h0, gi, gd);
    run_cycle(1, 16'h4, 1, 1, 16'h8, 16'h1234, gi, gd);
    rst_n = 1'b1;
    idle(1);

    // Fetch-only stream
    run_cycle(1, 16'h0, 0, 0, '0, '0, gi, gd);
    run_cycle(1, 16'h1, 0, 0, '0, '0, gi, gd);
    run_cycle(1, 16'h2, 0, 0, '0, '0, gi, gd);
    idle(4);

    // Load beats fetch, fetch follows
    run_cycle(1, 16'h4, 1, 0, 16'h20, '0, gi, gd);
    chk("t2_first_is_data", 32'(gd), 32'd1);
    run_cycle(1, 16'h4, 0, 0, '0, '0, gi, gd);
    chk("t2_then_fetch", 32'(gi), 32'd1);
    idle(4);

    // Starvation guard: D,D,D,IF,D,D,D,IF
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      run_cycle(1, AW'(i), 1, 0, AW'(16'h40 + i), '0, gi, gd);
      pat[i] = gd;
    end
    chk("t3_grant_pattern", 32'(pat), 32'h77);
    idle(4);

    // Store then load back
    run_cycle(0, '0, 1, 1, 16'h30, 16'hBEEF, gi, gd);
    idle(1);
    run_cycle(0, '0, 1, 0, 16'h30, '0, gi, gd);
    idle(4);

    // Alternating fetch/load reads every cycle
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) run_cycle(1, AW'(16'h10 + i), 0, 0, '0, '0, gi, gd);
      else            run_cycle(0, '0, 1, 0, AW'(16'h30 + i), '0, gi, gd);
    end
    idle(4);

    // Reset with loads in flight
    run_cycle(0, '0, 1, 0, 16'h10, '0, gi, gd);
    run_cycle(0, '0, 1, 0, 16'h11, '0, gi, gd);
    if_req = 1; d_req = 1;
    rst_n = 1'b0;
    #1;
    q_a.delete();
    q_b.delete();
    streak_m = 0;
    check_cycle(gi, gd);
    run_cycle(1, 16'h3, 1, 0, 16'h12, '0, gi, gd);
    rst_n = 1'b1;
    run_cycle(0, '0, 1, 0, 16'h12, '0, gi, gd);
    chk("t6_grant_after_release", 32'(gd), 32'd1);
    idle(5);

    // Randomized traffic honouring the hold-until-grant rule
    p_ir = 0; p_dr = 0; p_dwe = 0; p_ia = '0; p_da = '0; p_dwd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p_ir) begin
        p_ir = ($urandom_range(0, 99) < 60);
        p_ia = AW'($urandom_range(0, 15));
      end else if ($urandom_range(0, 19) == 0) begin
        p_ir = 0;
      end
      if (!p_dr) begin
        p_dr  = ($urandom_range(0, 99) < 60);
        p_dwe = ($urandom_range(0, 99) < 30);
        p_da  = AW'($urandom_range(0, 15));
        p_dwd = DW'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        p_dr = 0;
      end
      run_cycle(p_ir, p_ia, p_dr, p_dwe, p_da, p_dwd, gi, gd);
      if (gi) p_ir = 0;
      if (gd) p_dr = 0;
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
